// File: rtl/alu_pkg.sv
// Shared definitions for the serial add/subtract ALU slice.
// Contents: default widths, FSM state encoding, saturation constant helpers.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CNT_W = 3;
    localparam int unsigned MAX_WIDTH     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest positive two's-complement value of width w (0111..1), LSB-aligned.
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int unsigned w);
        return (MAX_WIDTH'(1) << (w - 1)) - MAX_WIDTH'(1);
    endfunction

    // Most negative two's-complement value of width w (1000..0), LSB-aligned.
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int unsigned w);
        return MAX_WIDTH'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/alu_serial_fa_cell.sv
// One-bit combinational full adder used by the serial add/sub engine.
// Ports: i_a, i_b, i_cin (addend bits and carry in); o_s (sum), o_cout (carry out).
module alu_serial_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/alu_serial_addsub.sv
// Bit-serial signed add/subtract engine. Accepts an operand pair on a
// valid/ready handshake, adds one bit per clock LSB-first, then presents the
// result with C/V/Z/N flags on a valid/ready output port.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, sub           operands (two's complement), 0 = A+B, 1 = A-B
//   out_valid/out_ready result handshake
//   result              sum/difference
//   carry               carry out of MSB (subtract: 1 = no borrow)
//   overflow            signed overflow
//   zero, negative      result == 0, result MSB
//
// Build option: define ALU_SERIAL_SATURATE_EN to clamp the result on signed
// overflow (carry/overflow still report the raw arithmetic).
module alu_serial_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_c;
    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_a_msb;
    logic               r_beff_msb;

    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_overflow;
    logic               r_zero;
    logic               r_negative;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_s;
    logic               w_cout;
    logic [WIDTH-1:0]   w_res_raw;
    logic [WIDTH-1:0]   w_res_fin;
    logic               w_ovf;

    // Single full-adder cell, reused on every SHIFT cycle.
    alu_serial_fa_cell u_fa (
        .i_a    (r_sh_a[0]),
        .i_b    (r_sh_b[0]),
        .i_cin  (r_c),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == SHIFT) && (r_cnt == LAST_CNT);
    assign w_b_eff  = sub ? ~b : b;

    // Accumulator after this cycle's sum bit enters from the MSB side; on the
    // last cycle this is the complete result.
    assign w_res_raw = {w_s, r_acc[WIDTH-1:1]};

    // Same-sign operands producing an opposite-sign result.
    assign w_ovf = (r_a_msb == r_beff_msb) && (w_s != r_a_msb);

`ifdef ALU_SERIAL_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    // Clamp toward the sign of A (both operands share it when overflow occurs).
    assign w_res_fin = w_ovf ? (r_a_msb ? SAT_MIN : SAT_MAX) : w_res_raw;
`else
    assign w_res_fin = w_res_raw;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Serial datapath: operand shifters, carry, counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_c        <= 1'b0;
            r_sh_a     <= '0;
            r_sh_b     <= '0;
            r_acc      <= '0;
            r_a_msb    <= 1'b0;
            r_beff_msb <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= '0;
            r_c        <= sub;
            r_sh_a     <= a;
            r_sh_b     <= w_b_eff;
            r_a_msb    <= a[WIDTH-1];
            r_beff_msb <= w_b_eff[WIDTH-1];
        end else if (r_state == SHIFT) begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_c    <= w_cout;
            r_sh_a <= r_sh_a >> 1;
            r_sh_b <= r_sh_b >> 1;
            r_acc  <= w_res_raw;
        end
    end

    // Presented result and flags; only change on the final SHIFT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
        end else if (w_last) begin
            r_result   <= w_res_fin;
            r_carry    <= w_cout;
            r_overflow <= w_ovf;
            r_zero     <= (w_res_fin == '0);
            r_negative <= w_res_fin[WIDTH-1];
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign zero      = r_zero;
    assign negative  = r_negative;

endmodule
